// File: rtl/cgia_bus_arbiter_if.sv
// cgia_bus_arbiter_if: fetcher, CPU and memory-side Wishbone signals of the arbiter.
// slave = arbiter view, master = surrounding masters plus memory.
interface cgia_bus_arbiter_if #(
  parameter int AW = 23
);
  logic          f_cyc_i;
  logic          f_stb_i;
  logic [AW-1:0] f_adr_i;
  logic          f_ack_o;
  logic [15:0]   f_dat_o;

  logic          c_cyc_i;
  logic          c_stb_i;
  logic          c_we_i;
  logic [AW-1:0] c_adr_i;
  logic [15:0]   c_dat_i;
  logic          c_ack_o;
  logic [15:0]   c_dat_o;

  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [15:0]   dat_o;
  logic          ack_i;
  logic [15:0]   dat_i;

  logic [1:0]    gnt_o;

  modport slave (
    input  f_cyc_i, f_stb_i, f_adr_i,
    output f_ack_o, f_dat_o,
    input  c_cyc_i, c_stb_i, c_we_i, c_adr_i, c_dat_i,
    output c_ack_o, c_dat_o,
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  ack_i, dat_i,
    output gnt_o
  );

  modport master (
    output f_cyc_i, f_stb_i, f_adr_i,
    input  f_ack_o, f_dat_o,
    output c_cyc_i, c_stb_i, c_we_i, c_adr_i, c_dat_i,
    input  c_ack_o, c_dat_o,
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output ack_i, dat_i,
    input  gnt_o
  );
endinterface

// File: rtl/cgia_bus_arbiter.sv
// cgia_bus_arbiter: shares one Wishbone classic slave between fetcher and CPU.
// Define CGIA_ARB_FAIRNESS_EN to let the CPU pre-empt long fetcher bursts.
module cgia_bus_arbiter #(
  parameter int AW        = 23,
  parameter int MAX_BURST = 8
) (
  input logic               clk_i,
  input logic               reset_ni,
  cgia_bus_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] FGNT = 2'b01;
  localparam logic [1:0] CGNT = 2'b10;

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("MAX_BURST must be 1..255");
  end

  logic [1:0] gnt;
  logic [1:0] gnt_d;
  logic       f_own;
  logic       c_own;

  assign f_own = (gnt == FGNT);
  assign c_own = (gnt == CGNT);

  assign bus.gnt_o   = gnt;
  assign bus.f_ack_o = bus.ack_i & f_own;
  assign bus.c_ack_o = bus.ack_i & c_own;
  assign bus.f_dat_o = bus.dat_i;
  assign bus.c_dat_o = bus.dat_i;

  // Slave side follows the registered owner, so reset drops cyc at once.
  always_comb begin
    bus.cyc_o = 1'b0;
    bus.stb_o = 1'b0;
    bus.we_o  = 1'b0;
    bus.adr_o = '0;
    bus.dat_o = '0;
    unique case (1'b1)
      f_own: begin
        bus.cyc_o = bus.f_cyc_i;
        bus.stb_o = bus.f_stb_i;
        bus.adr_o = bus.f_adr_i;
      end
      c_own: begin
        bus.cyc_o = bus.c_cyc_i;
        bus.stb_o = bus.c_stb_i;
        bus.we_o  = bus.c_we_i;
        bus.adr_o = bus.c_adr_i;
        bus.dat_o = bus.c_dat_i;
      end
      default: ;
    endcase
  end

`ifdef CGIA_ARB_FAIRNESS_EN
  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  logic [7:0] cnt;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc;
  logic       pre;
  logic       pre_d;

  assign cnt_inc = (cnt >= MAXB) ? MAXB : cnt + 8'd1;

  always_comb begin
    gnt_d = gnt;
    cnt_d = cnt;
    pre_d = pre;
    unique case (1'b1)
      f_own: begin
        if (!bus.f_cyc_i) begin
          gnt_d = bus.c_cyc_i ? CGNT : IDLE;
        end else if (bus.f_ack_o) begin
          cnt_d = cnt_inc;
          // Saturated count re-checks the CPU on every later ack.
          if (cnt_inc == MAXB && bus.c_cyc_i) begin
            gnt_d = CGNT;
            pre_d = 1'b1;
          end
        end
      end
      c_own: begin
        if (!bus.c_cyc_i) begin
          pre_d = 1'b0;
          if (bus.f_cyc_i) begin
            gnt_d = FGNT;
            cnt_d = '0;
          end else begin
            gnt_d = IDLE;
          end
        end
      end
      default: begin
        if (bus.f_cyc_i) begin
          gnt_d = FGNT;
          cnt_d = '0;
        end else if (bus.c_cyc_i) begin
          gnt_d = CGNT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt <= '0;
      pre <= 1'b0;
    end else begin
      cnt <= cnt_d;
      pre <= pre_d;
    end
  end
`else
  always_comb begin
    gnt_d = gnt;
    unique case (1'b1)
      f_own: begin
        if (!bus.f_cyc_i) begin
          gnt_d = bus.c_cyc_i ? CGNT : IDLE;
        end
      end
      c_own: begin
        if (!bus.c_cyc_i) begin
          gnt_d = bus.f_cyc_i ? FGNT : IDLE;
        end
      end
      default: begin
        if (bus.f_cyc_i) begin
          gnt_d = FGNT;
        end else if (bus.c_cyc_i) begin
          gnt_d = CGNT;
        end
      end
    endcase
  end
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      gnt <= IDLE;
    end else begin
      gnt <= gnt_d;
    end
  end

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// tb_cgia_bus_arbiter: vector table plus reset and burst sequences.
// The burst expectation follows CGIA_ARB_FAIRNESS_EN with MAX_BURST = 4.
module tb_cgia_bus_arbiter;

  localparam int BASE = 'h1000;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic        fc, fs;
    logic [22:0] fa;
    logic        cc, cs, cw;
    logic [22:0] ca;
    logic [15:0] cd;
    logic        ack;
    logic [15:0] sd;
    logic [1:0]  gnt;
    logic        cyc, stb, we;
    logic [22:0] adr;
    logic [15:0] dout;
    logic        fack, cack;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        auto = 1'b0;
  logic        ack_v = 1'b0;
  logic [15:0] sd_v = 16'h0;

  int n_vec = 0;
  int n_err = 0;

  cgia_bus_arbiter_if #(.AW(23)) bus ();

  assign bus.ack_i = auto ? (bus.cyc_o & bus.stb_o) : ack_v;
  assign bus.dat_i = auto ? (bus.adr_o[15:0] ^ 16'h5A5A) : sd_v;

  cgia_bus_arbiter #(.AW(23), .MAX_BURST(4)) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_f(input logic c, input logic s, input logic [22:0] a);
    bus.f_cyc_i = c;
    bus.f_stb_i = s;
    bus.f_adr_i = a;
  endtask

  task automatic drive_c(input logic c, input logic s, input logic w,
                         input logic [22:0] a, input logic [15:0] d);
    bus.c_cyc_i = c;
    bus.c_stb_i = s;
    bus.c_we_i  = w;
    bus.c_adr_i = a;
    bus.c_dat_i = d;
  endtask

  vec_t v[16];
  int   ev[32];
  int   exp_e[21];
  int   n_ev;
  int   fidx;
  logic cdone, fin, fa_s, ca_s;

  initial begin
    v[0]  = '{L,L,23'h0,     L,L,L,23'h0,16'h0,    L,16'h0,
              2'b00,L,L,L,23'h0,16'h0,L,L};
    v[1]  = '{H,H,23'h10,    H,H,L,23'h200,16'h5555,L,16'h0,
              2'b01,H,H,L,23'h10,16'h0,L,L};
    v[2]  = '{H,H,23'h10,    H,H,L,23'h200,16'h5555,H,16'h1234,
              2'b01,H,H,L,23'h10,16'h0,H,L};
    v[3]  = '{H,H,23'h11,    H,H,L,23'h200,16'h5555,L,16'h0,
              2'b01,H,H,L,23'h11,16'h0,L,L};
    v[4]  = '{L,L,23'h11,    H,H,L,23'h200,16'h5555,L,16'h0,
              2'b10,H,H,L,23'h200,16'h5555,L,L};
    v[5]  = '{L,L,23'h11,    H,H,L,23'h200,16'h5555,H,16'hA5A5,
              2'b10,H,H,L,23'h200,16'h5555,L,H};
    v[6]  = '{H,H,23'h20,    H,H,L,23'h200,16'h5555,H,16'h0F0F,
              2'b10,H,H,L,23'h200,16'h5555,L,H};
    v[7]  = '{H,H,23'h20,    L,L,L,23'h200,16'h5555,L,16'h0,
              2'b01,H,H,L,23'h20,16'h0,L,L};
    v[8]  = '{L,L,23'h20,    L,L,L,23'h0,16'h0,    L,16'h0,
              2'b00,L,L,L,23'h0,16'h0,L,L};
    v[9]  = '{L,L,23'h0,     H,H,H,23'h100,16'hBEEF,L,16'h0,
              2'b10,H,H,H,23'h100,16'hBEEF,L,L};
    v[10] = '{L,L,23'h0,     H,H,H,23'h100,16'hBEEF,H,16'h0001,
              2'b10,H,H,H,23'h100,16'hBEEF,L,H};
    v[11] = '{L,L,23'h0,     H,L,L,23'h100,16'hBEEF,L,16'h0,
              2'b10,H,L,L,23'h100,16'hBEEF,L,L};
    v[12] = '{L,L,23'h0,     L,L,L,23'h0,16'h0,    H,16'h7777,
              2'b00,L,L,L,23'h0,16'h0,L,L};
    v[13] = '{L,L,23'h0,     H,H,H,23'h300,16'h1111,L,16'h0,
              2'b10,H,H,H,23'h300,16'h1111,L,L};
    v[14] = '{H,H,23'h7FFFFF,L,L,H,23'h300,16'h1111,L,16'h0,
              2'b01,H,H,L,23'h7FFFFF,16'h0,L,L};
    v[15] = '{L,L,23'h7FFFFF,L,L,L,23'h0,16'h0,    H,16'h2222,
              2'b00,L,L,L,23'h0,16'h0,L,L};

    drive_f(L, L, 23'h0);
    drive_c(L, L, L, 23'h0, 16'h0);
    #1;
    chk("reset_state",
        96'({bus.gnt_o, bus.cyc_o, bus.stb_o, bus.we_o,
             bus.f_ack_o, bus.c_ack_o}), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_f(v[i].fc, v[i].fs, v[i].fa);
      drive_c(v[i].cc, v[i].cs, v[i].cw, v[i].ca, v[i].cd);
      ack_v = v[i].ack;
      sd_v  = v[i].sd;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          96'({bus.gnt_o, bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o,
               bus.dat_o, bus.f_ack_o, bus.c_ack_o, bus.f_dat_o,
               bus.c_dat_o}),
          96'({v[i].gnt, v[i].cyc, v[i].stb, v[i].we, v[i].adr,
               v[i].dout, v[i].fack, v[i].cack, v[i].sd, v[i].sd}));
    end

    // Reset lands while the fetcher owns the bus with ack pending.
    @(negedge clk);
    drive_f(H, H, 23'h40);
    drive_c(L, L, L, 23'h0, 16'h0);
    ack_v = L;
    @(posedge clk);
    #1;
    chk("rst_pre_gnt", 96'({bus.gnt_o, bus.cyc_o}), 96'({2'b01, H}));
    ack_v = H;
    #1;
    chk("rst_pre_ack", 96'(bus.f_ack_o), 96'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_async",
        96'({bus.cyc_o, bus.gnt_o, bus.f_ack_o, bus.c_ack_o}), 96'(0));
    @(negedge clk);
    drive_f(L, L, 23'h0);
    ack_v = L;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release",
        96'({bus.gnt_o, bus.cyc_o, bus.f_ack_o, bus.c_ack_o}), 96'(0));

    // 20-word fetch, CPU write request arriving after word 2.
`ifdef CGIA_ARB_FAIRNESS_EN
    for (int i = 0; i < 4; i++) exp_e[i] = i;
    exp_e[4] = 999;
    for (int i = 4; i < 20; i++) exp_e[i + 1] = i;
`else
    for (int i = 0; i < 20; i++) exp_e[i] = i;
    exp_e[20] = 999;
`endif
    for (int i = 0; i < 32; i++) ev[i] = -1;
    auto  = 1'b1;
    fidx  = 0;
    n_ev  = 0;
    cdone = 1'b0;
    fin   = 1'b0;
    @(negedge clk);
    drive_f(H, H, 23'(BASE));
    drive_c(L, L, H, 23'h50, 16'hCAFE);
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clk);
      fa_s = bus.f_ack_o;
      ca_s = bus.c_ack_o;
      if (fa_s) begin
        if (n_ev < 32) ev[n_ev] = fidx;
        n_ev++;
        chk($sformatf("burst_fdat%0d", fidx), 96'(bus.f_dat_o),
            96'(16'(BASE + fidx) ^ 16'h5A5A));
      end
      if (ca_s) begin
        if (n_ev < 32) ev[n_ev] = 999;
        n_ev++;
        chk("burst_cwrite", 96'({bus.we_o, bus.adr_o, bus.dat_o}),
            96'({H, 23'h50, 16'hCAFE}));
      end
      @(posedge clk);
      #1;
      if (fa_s) fidx++;
      if (ca_s) cdone = 1'b1;
      drive_f(fidx < 20, fidx < 20, 23'(BASE + fidx));
      bus.c_cyc_i = (fidx >= 2) && !cdone;
      bus.c_stb_i = (fidx >= 2) && !cdone;
      fin = (fidx == 20) && cdone;
    end
    chk("burst_finished", 96'(fin), 96'(1));
    chk("burst_event_count", 96'(n_ev), 96'(21));
    for (int i = 0; i < 21; i++)
      chk($sformatf("burst_order%0d", i), 96'(ev[i]), 96'(exp_e[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
